// File: rtl/display_scan_ctrl.sv
// Two-digit common-anode scan controller: time-multiplexes one hex decoder with blanking
// gaps, and commits load/ack handshaked values only at the frame boundary (SHOW1 -> BLANK1).
module display_scan_ctrl #(
  parameter int REFRESH_CYCLES = 20000,
  parameter int BLANK_CYCLES   = 400,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  output logic [3:0] hex,
  output logic [1:0] an,
  output logic       ack
);

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       an_q, an_d;
  logic [3:0]       hex_q, hex_d;
  logic [3:0]       act0_q, act0_d, act1_q, act1_d;
  logic [3:0]       pend0_q, pend0_d, pend1_q, pend1_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             slot_last;
  logic             commit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BLANK1;
      cnt_q   <= '0;
      an_q    <= 2'b11;
      hex_q   <= 4'h0;
      act0_q  <= 4'h0;
      act1_q  <= 4'h0;
      pend0_q <= 4'h0;
      pend1_q <= 4'h0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      hex_q   <= hex_d;
      act0_q  <= act0_d;
      act1_q  <= act1_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    an_d    = an_q;
    hex_d   = hex_q;
    act0_d  = act0_q;
    act1_d  = act1_q;
    pend0_d = pend0_q;
    pend1_d = pend1_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;

    if (state_q == SHOW0 || state_q == SHOW1) begin
      slot_last = (cnt_q == SHOW_LAST);
    end else begin
      slot_last = (cnt_q == BLANK_LAST);
    end
    commit = slot_last && (state_q == SHOW1) && pend_q;

    if (slot_last) begin
      cnt_d = '0;
      unique case (state_q)
        SHOW0:   state_d = BLANK0;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = BLANK1;
        default: state_d = SHOW0;
      endcase
    end

    // Anodes are registered alongside the state so they switch on the same edge.
    unique case (state_d)
      SHOW0:   an_d = 2'b10;
      SHOW1:   an_d = 2'b01;
      default: an_d = 2'b11;
    endcase

    // hex only moves when entering a blank slot, giving the decoder time to settle.
    if (slot_last && state_q == SHOW0) begin
      hex_d = act1_q;
    end
    if (slot_last && state_q == SHOW1) begin
      hex_d = commit ? pend0_q : act0_q;
    end

    if (commit) begin
      act0_d = pend0_q;
      act1_d = pend1_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end

    // A load coinciding with a commit becomes the next pending frame.
    if (load) begin
      pend0_d = d0;
      pend1_d = d1;
      pend_d  = 1'b1;
    end
  end

  assign hex = hex_q;
  assign an  = an_q;
  assign ack = ack_q;

endmodule
